// File: rtl/ecpri_ram_writer.sv
// ecpri_ram_writer: parses the 4-byte eCPRI common header, writes payload bytes into a
// circular RAM and hands one descriptor per clean message to the downstream consumer.
module ecpri_ram_writer #(
    parameter int         ADDR_WIDTH = 16,
    parameter int         DATA_WIDTH = 8,
    parameter int         RAM_DEPTH  = 16,
    parameter logic [3:0] ECPRI_REV  = 4'h1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_sop,
    input  logic                  s_eop,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic                  desc_valid,
    input  logic                  desc_ready,
    output logic [ADDR_WIDTH-1:0] desc_addr,
    output logic [15:0]           desc_len,
    output logic [7:0]            desc_type,
    output logic                  err_pulse
);

    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, DESC, DROP} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    state_t                  state, state_next;
    logic [1:0]              hdr_cnt, hdr_cnt_next;
    logic [3:0]              rev, rev_next;
    logic [7:0]              msg_type, type_next;
    logic [7:0]              size_hi, size_hi_next;
    logic [15:0]             size_q, size_next;
    logic [15:0]             pay_cnt, pay_cnt_next;
    logic [ADDR_WIDTH-1:0]   wr_ptr, wr_ptr_next;
    logic [ADDR_WIDTH-1:0]   start_addr, start_next;
    logic [DATA_WIDTH-1:0]   wdata, wdata_next;
    logic [ADDR_WIDTH-1:0]   addr_next, daddr_next;
    logic [15:0]             dlen_next;
    logic [7:0]              dtype_next;
    logic                    we_next, dvalid_next, err_next;

    logic                    xfer;
    logic [15:0]             hdr_size;
    logic [ADDR_WIDTH-1:0]   ptr_inc;
    logic [15:0]             pay_cnt_inc;

    assign xfer        = s_valid & s_ready;
    assign hdr_size    = {size_hi, s_data[7:0]};
    assign ptr_inc     = (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + ADDR_WIDTH'(1);
    assign pay_cnt_inc = pay_cnt + 16'd1;

    assign ram_cs   = ram_we;
    assign ram_oe   = 1'b0;
    assign ram_data = ram_we ? wdata : {DATA_WIDTH{1'bz}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hdr_cnt    <= '0;
            rev        <= '0;
            msg_type   <= '0;
            size_hi    <= '0;
            size_q     <= '0;
            pay_cnt    <= '0;
            wr_ptr     <= '0;
            start_addr <= '0;
            wdata      <= '0;
            s_ready    <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            desc_valid <= 1'b0;
            desc_addr  <= '0;
            desc_len   <= '0;
            desc_type  <= '0;
            err_pulse  <= 1'b0;
        end else begin
            state      <= state_next;
            hdr_cnt    <= hdr_cnt_next;
            rev        <= rev_next;
            msg_type   <= type_next;
            size_hi    <= size_hi_next;
            size_q     <= size_next;
            pay_cnt    <= pay_cnt_next;
            wr_ptr     <= wr_ptr_next;
            start_addr <= start_next;
            wdata      <= wdata_next;
            s_ready    <= (state_next != DESC);
            ram_we     <= we_next;
            ram_addr   <= addr_next;
            desc_valid <= dvalid_next;
            desc_addr  <= daddr_next;
            desc_len   <= dlen_next;
            desc_type  <= dtype_next;
            err_pulse  <= err_next;
        end
    end

    always_comb begin
        state_next   = state;
        hdr_cnt_next = hdr_cnt;
        rev_next     = rev;
        type_next    = msg_type;
        size_hi_next = size_hi;
        size_next    = size_q;
        pay_cnt_next = pay_cnt;
        wr_ptr_next  = wr_ptr;
        start_next   = start_addr;
        wdata_next   = wdata;
        we_next      = 1'b0;
        addr_next    = ram_addr;
        dvalid_next  = desc_valid;
        daddr_next   = desc_addr;
        dlen_next    = desc_len;
        dtype_next   = desc_type;
        err_next     = 1'b0;

        case (state)
            IDLE: begin
                if (xfer && s_sop) begin
                    rev_next = s_data[7:4];
                    if (s_eop) begin
                        err_next = 1'b1;
                    end else begin
                        hdr_cnt_next = 2'd1;
                        state_next   = HDR;
                    end
                end
            end
            HDR: begin
                if (xfer) begin
                    if (hdr_cnt != 2'd3) begin
                        if (s_eop || s_sop) begin
                            err_next   = 1'b1;
                            state_next = IDLE;
                        end else begin
                            if (hdr_cnt == 2'd1) type_next = s_data[7:0];
                            else                 size_hi_next = s_data[7:0];
                            hdr_cnt_next = hdr_cnt + 2'd1;
                        end
                    end else begin
                        size_next = hdr_size;
                        // A bad header that already carries eop has nothing left to discard.
                        if (rev != ECPRI_REV || int'(hdr_size) > RAM_DEPTH ||
                            (s_eop && hdr_size != 16'd0)) begin
                            if (s_eop) begin
                                err_next   = 1'b1;
                                state_next = IDLE;
                            end else begin
                                state_next = DROP;
                            end
                        end else if (s_eop) begin
                            state_next  = DESC;
                            dvalid_next = 1'b1;
                            daddr_next  = wr_ptr;
                            dlen_next   = 16'd0;
                            dtype_next  = msg_type;
                        end else begin
                            state_next   = PAYLOAD;
                            start_next   = wr_ptr;
                            pay_cnt_next = 16'd0;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    we_next      = 1'b1;
                    addr_next    = wr_ptr;
                    wdata_next   = s_data;
                    wr_ptr_next  = ptr_inc;
                    pay_cnt_next = pay_cnt_inc;
                    if (s_eop && pay_cnt_inc == size_q) begin
                        state_next  = DESC;
                        dvalid_next = 1'b1;
                        daddr_next  = start_addr;
                        dlen_next   = size_q;
                        dtype_next  = msg_type;
                    end else if (s_eop) begin
                        err_next    = 1'b1;
                        state_next  = IDLE;
                        wr_ptr_next = start_addr;
                    end else if (pay_cnt_inc >= size_q) begin
                        state_next  = DROP;
                        wr_ptr_next = start_addr;
                    end
                end
            end
            DESC: begin
                if (desc_ready) begin
                    dvalid_next = 1'b0;
                    state_next  = IDLE;
                end
            end
            DROP: begin
                if (xfer && s_eop) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/ecpri_ram_writer.md
Name: ecpri_ram_writer

Overview:
Upstream stage of ecpri_ram. Accepts an eCPRI message byte stream with valid/ready and sop/eop, and parses the 4-byte common header. Payload bytes are written sequentially into ecpri_ram through its clk/addr/data/cs/we/oe port, as a circular buffer. For each clean message the block emits one descriptor (start address, length, message type) to the downstream consumer; malformed messages are dropped and flagged.

Parameters:
ADDR_WIDTH, 16, ecpri_ram address width
DATA_WIDTH, 8, byte width of stream and RAM data
RAM_DEPTH, 16, number of RAM locations; write pointer wraps modulo RAM_DEPTH
ECPRI_REV, 4'h1, required value of header byte0[7:4]

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
s_data  in  DATA_WIDTH  stream byte
s_valid  in  1  byte valid
s_sop  in  1  first byte of message (qualified by s_valid)
s_eop  in  1  last byte of message (qualified by s_valid)
s_ready  out  1  block can accept a byte this cycle
ram_addr  out  ADDR_WIDTH  RAM address
ram_data  inout  DATA_WIDTH  RAM data; driven only while ram_we=1, else high-Z
ram_cs  out  1  RAM chip select
ram_we  out  1  RAM write enable
ram_oe  out  1  RAM output enable; tied 0 (block never reads)
desc_valid  out  1  descriptor available
desc_ready  in  1  consumer accepts descriptor
desc_addr  out  ADDR_WIDTH  RAM address of first payload byte
desc_len  out  16  payload byte count
desc_type  out  8  eCPRI message type (header byte1)
err_pulse  out  1  one-cycle pulse when a message is dropped

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; wr_ptr=0; s_ready=0; ram_cs=0, ram_we=0, ram_oe=0, ram_addr=0, ram_data=Z; desc_valid=0, desc_addr=0, desc_len=0, desc_type=0; err_pulse=0. Reset mid-message aborts it: no descriptor, no error pulse, wr_ptr returns to 0.
- Byte transfer = s_valid & s_ready at a rising edge.
- States: IDLE, HDR, PAYLOAD, DESC, DROP.
- IDLE: s_ready=1. Transfers without s_sop are discarded silently. On a transfer with s_sop, capture byte0 and go to HDR with hdr_cnt=1.
- HDR: s_ready=1. Capture byte1 as type, byte2 as size[15:8], byte3 as size[7:0], then evaluate on the byte3 transfer:
  - Go to DROP if any of: rev mismatch; size > RAM_DEPTH; s_eop on byte3 with size!=0.
  - s_eop on byte3 with size==0 -> DESC, desc_len=0.
  - Otherwise -> PAYLOAD, start_addr=wr_ptr.
  - s_eop or a new s_sop during bytes 0..2 -> error pulse, return to IDLE.
- PAYLOAD: s_ready=1. Each transfer writes one byte. Registered, 1-cycle latency: the next cycle has ram_cs=1, ram_we=1, ram_addr=wr_ptr, ram_data=byte. wr_ptr increments, RAM_DEPTH-1 wraps to 0. ram_cs and ram_we return to 0 in cycles with no write.
  - s_eop on byte number size -> DESC.
  - s_eop before byte number size (truncated) -> err_pulse, IDLE. Bytes already written stay in RAM; wr_ptr is restored to start_addr.
  - Byte number size without s_eop (overlong) -> DROP, wr_ptr restored to start_addr.
- DROP: s_ready=1. Discard until the s_eop transfer, then pulse err_pulse for 1 cycle and go to IDLE.
- DESC: s_ready=0. desc_valid=1 with desc_addr=start_addr, desc_len=size, desc_type=type, all held stable until desc_valid & desc_ready. On that edge desc_valid=0 and the state goes to IDLE. A descriptor is consumed at most once.
- desc_ready high outside DESC has no effect.
- No read-pointer backpressure: overwriting old payload is the consumer's responsibility.
- Latency: the last payload byte is written to RAM the cycle after its transfer; desc_valid rises in the same cycle.

Test Plan:
- Reset, then message 10 40 00 03 AA BB CC (eop on CC) -> RAM[0..2]=AA,BB,CC; desc_addr=0, desc_len=3, desc_type=0x40; wr_ptr=3.
- Second message after that one, size 15, bytes 01..0F -> writes RAM[3..15] then RAM[0..1]; desc_addr=3, desc_len=15.
- Byte0=0x20 (bad rev), size 2 -> no RAM write, no descriptor, err_pulse exactly once on the eop cycle.
- Size 4 with eop on payload byte 2 -> err_pulse, no descriptor; next message starts at the same desc_addr.
- Zero-size message 10 02 00 00 with eop -> desc_len=0, no RAM write. Hold desc_ready=0 for 5 cycles -> s_ready=0 and the descriptor stays stable.
- rst pulsed during PAYLOAD of a size-8 message -> all outputs at reset values; the next message writes from address 0.
